fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, queues in-order
// responses, and squashes in-flight fetches on redirect.
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid_F,
  output logic [31:0]       inst_F,
  output logic [XLEN-1:0]   pc_F,
  output logic [XLEN-1:0]   pc_plus4_F,
  input  logic              dec_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      inst_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];

  logic             req_fire_s;
  logic             resp_take_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W:0]   occupancy_s;
  logic [XLEN-1:0]  redirect_base_s;
  logic             unused_ok_s;

  // Queue slots plus in-flight requests bound the number of new requests.
  assign occupancy_s     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid  = !reset && !redirect_valid &&
                           (occupancy_s < (CNT_W+1)'(DEPTH));
  assign imem_req_addr   = fetch_pc_q;
  assign redirect_base_s = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_ok_s     = ^redirect_pc[1:0];

  assign req_fire_s  = imem_req_valid && imem_req_ready;
  assign resp_take_s = imem_resp_valid && (outstanding_q != {CNT_W{1'b0}});
  assign push_s      = resp_take_s && (drop_q == {CNT_W{1'b0}}) && !redirect_valid;
  assign pop_s       = (count_q != {CNT_W{1'b0}}) && dec_ready && !redirect_valid;

  assign inst_valid_F = (count_q != {CNT_W{1'b0}});
  assign inst_F       = inst_mem_q[head_q];
  assign pc_F         = pc_mem_q[head_q];
  assign pc_plus4_F   = pc_mem_q[head_q] + XLEN'(4);

  always_comb begin
    fetch_pc_d    = req_fire_s ? (fetch_pc_q + XLEN'(4)) : fetch_pc_q;
    resp_pc_d     = push_s ? (resp_pc_q + XLEN'(4)) : resp_pc_q;
    tail_d        = push_s ? (tail_q + PTR_W'(1)) : tail_q;
    head_d        = pop_s ? (head_q + PTR_W'(1)) : head_q;

    case ({req_fire_s, resp_take_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (resp_take_s && (drop_q != {CNT_W{1'b0}})) begin
      drop_d = drop_q - CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end

    // Stale responses are still counted in outstanding, so after a redirect
    // every request still in flight (stale or not) is the set to discard.
    if (redirect_valid) begin
      fetch_pc_d = redirect_base_s;
      resp_pc_d  = redirect_base_s;
      count_d    = {CNT_W{1'b0}};
      head_d     = {PTR_W{1'b0}};
      tail_d     = {PTR_W{1'b0}};
      drop_d     = outstanding_d;
    end else begin
      drop_d     = drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= {CNT_W{1'b0}};
      outstanding_q <= {CNT_W{1'b0}};
      drop_q        <= {CNT_W{1'b0}};
      head_q        <= {PTR_W{1'b0}};
      tail_q        <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i]   <= {XLEN{1'b0}};
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      if (push_s) begin
        inst_mem_q[tail_q] <= imem_resp_data;
        pc_mem_q[tail_q]   <= resp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, inst_F, pc_F, pc_plus4_F;
  logic        redirect_valid, inst_valid_F, dec_ready;

  logic        w_reset, w_req_valid, w_req_ready, w_resp_valid, w_redirect, w_inst_valid, w_dec;
  logic [31:0] w_req_addr, w_resp_data, w_redirect_pc, w_inst, w_pc, w_pc4;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid_F(inst_valid_F), .inst_F(inst_F), .pc_F(pc_F), .pc_plus4_F(pc_plus4_F),
    .dec_ready(dec_ready)
  );

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) w_dut (
    .clk(clk), .reset(w_reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .inst_valid_F(w_inst_valid), .inst_F(w_inst), .pc_F(w_pc), .pc_plus4_F(w_pc4),
    .dec_ready(w_dec)
  );

  int checks = 0;
  int passes = 0;

  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct {
    logic rst, rdy, resp_en, dec, chk_inst, e_req_valid;
    logic [31:0] e_req_addr;
    logic e_inst_valid;
    logic [31:0] e_pc;
  } vec_t;

  infl_t       m_inflight[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] mem_q[$];
  logic [31:0] w_mem_q[$];
  bit          model_on = 1'b0;
  vec_t        tbl[20];

  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_req_addr, s_inst, s_pc, s_pc4;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock of the main DUT: drive at negedge, check against the model, advance.
  task automatic drive_cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                             input logic rdy, input logic resp_en, input logic dec);
    logic  e_req_valid, fire, got;
    infl_t f;
    ent_t  ne;
    reset = rst; redirect_valid = redir; redirect_pc = rpc;
    imem_req_ready = rdy; dec_ready = dec;
    if (resp_en && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1; imem_resp_data = word_of(mem_q[0]);
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_inst_valid = inst_valid_F; s_inst = inst_F; s_pc = pc_F; s_pc4 = pc_plus4_F;

    e_req_valid = !rst && !redir && ((m_q.size() + m_inflight.size()) < DEPTH);
    if (model_on) begin
      chk("model_req_valid", s_req_valid, e_req_valid);
      if (e_req_valid) chk("model_req_addr", s_req_addr, m_fetch_pc);
      chk("model_inst_valid", s_inst_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("model_pc_F", s_pc, m_q[0].pc);
        chk("model_inst_F", s_inst, m_q[0].inst);
        chk("model_pc_plus4_F", s_pc4, m_q[0].pc + 32'd4);
      end
    end

    if (imem_resp_valid) void'(mem_q.pop_front());
    if (s_req_valid && rdy) mem_q.push_back(s_req_addr);

    if (rst) begin
      m_fetch_pc = 32'h0000_0000; m_inflight.delete(); m_q.delete();
    end else begin
      fire = e_req_valid && rdy;
      got = 1'b0;
      if (imem_resp_valid && m_inflight.size() > 0) begin
        f = m_inflight.pop_front();
        if (!f.stale && !redir) begin
          got = 1'b1; ne.inst = imem_resp_data; ne.pc = f.addr;
        end
      end
      if (!redir && dec && m_q.size() > 0) void'(m_q.pop_front());
      if (got) m_q.push_back(ne);
      if (fire) begin
        f.addr = m_fetch_pc; f.stale = 1'b0;
        m_inflight.push_back(f);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redir) begin
        foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
        m_q.delete();
        m_fetch_pc = {rpc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_clean();
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (mem_q.size() == 0) break;
    end
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (s_inst_valid) begin
        found = 1'b1;
        chk({name, "_pc"}, s_pc, exp_pc);
        chk({name, "_inst"}, s_inst, word_of(exp_pc));
      end
    end
    chk({name, "_delivered"}, {31'd0, found}, 32'd1);
  endtask

  task automatic setv(input int i, input logic rst, input logic rdy, input logic re,
                      input logic dec, input logic ci, input logic erv,
                      input logic [31:0] era, input logic eiv, input logic [31:0] epc);
    tbl[i].rst = rst; tbl[i].rdy = rdy; tbl[i].resp_en = re; tbl[i].dec = dec;
    tbl[i].chk_inst = ci; tbl[i].e_req_valid = erv; tbl[i].e_req_addr = era;
    tbl[i].e_inst_valid = eiv; tbl[i].e_pc = epc;
  endtask

  // Wrap-around instance: always ready, one-cycle responses, decode always ready.
  task automatic w_cycle(input logic rst);
    w_reset = rst; w_req_ready = 1'b1; w_dec = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    if (w_mem_q.size() > 0) begin
      w_resp_valid = 1'b1; w_resp_data = word_of(w_mem_q[0]);
    end else begin
      w_resp_valid = 1'b0; w_resp_data = 32'h0;
    end
    #1;
    s_req_valid = w_req_valid; s_req_addr = w_req_addr;
    s_inst_valid = w_inst_valid; s_inst = w_inst; s_pc = w_pc; s_pc4 = w_pc4;
    if (w_resp_valid) void'(w_mem_q.pop_front());
    if (w_req_valid && !rst) w_mem_q.push_back(w_req_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] wexp [3];
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; dec_ready = 1'b0;
    w_reset = 1'b1; w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 32'h0;
    w_redirect = 1'b0; w_redirect_pc = 32'h0; w_dec = 1'b0;

    //      i  rst rdy re dec chk rv  addr           iv  pc
    setv( 0, 1, 1, 1, 1, 1, 0, 32'h0,          0, 32'h0);
    setv( 1, 0, 1, 1, 1, 1, 1, 32'h0,          0, 32'h0);
    setv( 2, 0, 1, 1, 1, 1, 1, 32'h4,          0, 32'h0);
    setv( 3, 0, 1, 1, 1, 1, 1, 32'h8,          1, 32'h0);
    setv( 4, 0, 1, 1, 1, 1, 1, 32'hC,          1, 32'h4);
    setv( 5, 0, 1, 1, 1, 1, 1, 32'h10,         1, 32'h8);
    setv( 6, 0, 1, 1, 1, 1, 1, 32'h14,         1, 32'hC);
    setv( 7, 1, 1, 1, 1, 0, 0, 32'h0,          0, 32'h0);
    setv( 8, 0, 1, 1, 0, 1, 1, 32'h0,          0, 32'h0);
    setv( 9, 0, 1, 1, 0, 1, 1, 32'h4,          0, 32'h0);
    setv(10, 0, 1, 1, 0, 1, 1, 32'h8,          1, 32'h0);
    setv(11, 0, 1, 1, 0, 1, 1, 32'hC,          1, 32'h0);
    setv(12, 0, 1, 1, 0, 1, 0, 32'h0,          1, 32'h0);
    setv(13, 0, 1, 1, 0, 1, 0, 32'h0,          1, 32'h0);
    setv(14, 0, 1, 1, 1, 1, 0, 32'h0,          1, 32'h0);
    setv(15, 0, 1, 1, 1, 1, 1, 32'h10,         1, 32'h4);
    setv(16, 0, 1, 1, 1, 1, 1, 32'h14,         1, 32'h8);
    setv(17, 0, 1, 1, 1, 1, 1, 32'h18,         1, 32'hC);
    setv(18, 0, 1, 1, 1, 1, 1, 32'h1C,         1, 32'h10);
    setv(19, 0, 1, 1, 1, 1, 1, 32'h20,         1, 32'h14);

    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    model_on = 1'b1;

    // Streaming, reset, then backpressure with a full queue.
    for (int i = 0; i < 20; i++) begin
      drive_cycle(tbl[i].rst, 1'b0, 32'h0, tbl[i].rdy, tbl[i].resp_en, tbl[i].dec);
      chk($sformatf("tbl%0d_req_valid", i), s_req_valid, tbl[i].e_req_valid);
      if (tbl[i].e_req_valid) chk($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].e_req_addr);
      if (tbl[i].chk_inst) begin
        chk($sformatf("tbl%0d_inst_valid", i), s_inst_valid, tbl[i].e_inst_valid);
        if (tbl[i].e_inst_valid) begin
          chk($sformatf("tbl%0d_pc_F", i), s_pc, tbl[i].e_pc);
          chk($sformatf("tbl%0d_inst_F", i), s_inst, word_of(tbl[i].e_pc));
        end
      end
    end

    // Redirect with three requests outstanding.
    reset_clean();
    repeat (3) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b1);
    chk("redir_req_gated", s_req_valid, 1'b0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("redir_next_req_valid", s_req_valid, 1'b1);
    chk("redir_next_req_addr", s_req_addr, 32'h100);
    chk("redir_queue_empty", s_inst_valid, 1'b0);
    wait_first("redir3", 32'h100);

    // Redirect coinciding with a response and a consumable head.
    reset_clean();
    repeat (2) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("coinc_head_valid", s_inst_valid, 1'b1);
    chk("coinc_head_pc", s_pc, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("coinc_no_redeliver", s_inst_valid, 1'b0);
    chk("coinc_req_addr", s_req_addr, 32'h200);
    wait_first("coinc", 32'h200);

    // Reset with two requests in flight; their responses arrive late.
    reset_clean();
    repeat (2) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("rst_mid_inst_valid", s_inst_valid, 1'b0);
    chk("rst_mid_req_valid", s_req_valid, 1'b1);
    chk("rst_mid_req_addr", s_req_addr, 32'h0);
    wait_first("rst_mid", 32'h0);

    // Randomized traffic including back-to-back redirects.
    for (int i = 0; i < 1500; i++) begin
      logic redir;
      redir = ($urandom_range(0, 15) == 0) || ((i % 250) < 2);
      drive_cycle(1'b0, redir, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Address wrap-around on the second instance.
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    n = 0;
    w_cycle(1'b1);
    for (int c = 1; c <= 5; c++) begin
      w_cycle(1'b0);
      if (c == 3) chk("wrap_req_addr", s_req_addr, 32'h0000_0000);
      if (s_inst_valid && n < 3) begin
        chk($sformatf("wrap_pc%0d", n), s_pc, wexp[n]);
        chk($sformatf("wrap_inst%0d", n), s_inst, word_of(wexp[n]));
        if (wexp[n] == 32'hFFFF_FFFC) chk("wrap_pc_plus4", s_pc4, 32'h0000_0000);
        n++;
      end
    end
    chk("wrap_delivered", n, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
